// File: rtl/ram512_copy_engine_if.sv
// Copy-engine bus: request/status handshake plus single-port memory port.
// Optional fill-mode signals exist only when RAM512_COPY_FILL_MODE_EN is defined.
interface ram512_copy_engine_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 9
);
    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic              mem_en;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_in;
    logic [DATA_W-1:0] mem_out;
`ifdef RAM512_COPY_FILL_MODE_EN
    logic              fill;
    logic [DATA_W-1:0] fill_value;

    // Requester and memory side
    modport master (
        output start, src_addr, dst_addr, len, fill, fill_value, mem_out,
        input  busy, done, mem_en, mem_rw, mem_address, mem_in
    );

    // Copy engine side
    modport slave (
        input  start, src_addr, dst_addr, len, fill, fill_value, mem_out,
        output busy, done, mem_en, mem_rw, mem_address, mem_in
    );
`else
    // Requester and memory side
    modport master (
        output start, src_addr, dst_addr, len, mem_out,
        input  busy, done, mem_en, mem_rw, mem_address, mem_in
    );

    // Copy engine side
    modport slave (
        input  start, src_addr, dst_addr, len, mem_out,
        output busy, done, mem_en, mem_rw, mem_address, mem_in
    );
`endif
endinterface

// File: rtl/ram512_copy_engine.sv
// Word-by-word memory copy engine over a single-port RAM (read, then write).
// Optional fill mode (writes a constant, no reads) enabled by defining
// RAM512_COPY_FILL_MODE_EN.
module ram512_copy_engine #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 9
) (
    input  logic                    clk,
    input  logic                    rst_n,
    ram512_copy_engine_if.slave     bus
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W+1)'(1);

    state_t            state_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   idx_q;
    logic [DATA_W-1:0] hold_q;
    logic              fill_q;
    logic              busy_q;
    logic              done_q;
    logic              mem_en_q;
    logic              mem_rw_q;
    logic [ADDR_W-1:0] mem_addr_q;

    logic [ADDR_W:0]   len_d;
    logic [ADDR_W:0]   idx_d;
    logic              more_d;
    logic [ADDR_W-1:0] src_nxt_d;
    logic [ADDR_W-1:0] dst_cur_d;
    logic [ADDR_W-1:0] dst_nxt_d;
    logic              fill_start_d;
    logic [DATA_W-1:0] fill_val_d;

`ifdef RAM512_COPY_FILL_MODE_EN
    assign fill_start_d = bus.fill;
    assign fill_val_d   = bus.fill_value;
`else
    assign fill_start_d = 1'b0;
    assign fill_val_d   = '0;
`endif

    // Count clamp, next index and modulo address arithmetic
    always_comb begin
        len_d     = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
        idx_d     = idx_q + IDX_ONE;
        more_d    = (idx_d < len_q);
        src_nxt_d = src_q + idx_d[ADDR_W-1:0];
        dst_cur_d = dst_q + idx_q[ADDR_W-1:0];
        dst_nxt_d = dst_q + idx_d[ADDR_W-1:0];
    end

    // Control FSM; all memory-port outputs are registered and loaded one
    // edge ahead with the values for the state being entered. hold_q doubles
    // as the write-data register and is cleared outside WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            idx_q      <= '0;
            hold_q     <= '0;
            fill_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_en_q   <= 1'b0;
            mem_rw_q   <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        src_q  <= bus.src_addr;
                        dst_q  <= bus.dst_addr;
                        len_q  <= len_d;
                        idx_q  <= '0;
                        fill_q <= fill_start_d;
                        busy_q <= 1'b1;
                        if (len_d == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (fill_start_d) begin
                            state_q    <= WRITE;
                            mem_en_q   <= 1'b1;
                            mem_rw_q   <= 1'b1;
                            mem_addr_q <= bus.dst_addr;
                            hold_q     <= fill_val_d;
                        end else begin
                            state_q    <= READ;
                            mem_en_q   <= 1'b1;
                            mem_rw_q   <= 1'b0;
                            mem_addr_q <= bus.src_addr;
                        end
                    end
                end
                READ: begin
                    state_q    <= WRITE;
                    hold_q     <= bus.mem_out;
                    mem_rw_q   <= 1'b1;
                    mem_addr_q <= dst_cur_d;
                end
                WRITE: begin
                    idx_q <= idx_d;
                    if (more_d) begin
                        if (fill_q) begin
                            mem_addr_q <= dst_nxt_d;
                        end else begin
                            state_q    <= READ;
                            mem_rw_q   <= 1'b0;
                            mem_addr_q <= src_nxt_d;
                            hold_q     <= '0;
                        end
                    end else begin
                        state_q    <= DONE;
                        done_q     <= 1'b1;
                        mem_en_q   <= 1'b0;
                        mem_rw_q   <= 1'b0;
                        mem_addr_q <= '0;
                        hold_q     <= '0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_rw      = mem_rw_q;
    assign bus.mem_address = mem_addr_q;
    assign bus.mem_in      = hold_q;

endmodule

// File: tb/tb_ram512_copy_engine.sv
// Self-checking bench for ram512_copy_engine: table of directed copies,
// randomized copies against a queue/array reference model, and hand-written
// start-hold and mid-operation reset sequences.
module tb_ram512_copy_engine;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 9;
    localparam int unsigned DEPTH = 512;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ram512_copy_engine_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    ram512_copy_engine #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural RAM: combinational read, write applied mid-cycle while the
    // registered engine outputs are stable.
    logic [DW-1:0] mem [DEPTH];

    always_comb bus.mem_out = (bus.mem_en && !bus.mem_rw) ? mem[bus.mem_address] : '0;

    always @(negedge clk) begin
        if (bus.mem_en && bus.mem_rw) mem[bus.mem_address] = bus.mem_in;
    end

    typedef struct {
        logic          rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } acc_t;

    typedef struct {
        string       name;
        int unsigned src;
        int unsigned dst;
        int unsigned len;
        int unsigned exp_done;
    } vec_t;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({bus.busy, bus.done, bus.mem_en, bus.mem_rw, bus.mem_address, bus.mem_in});
    endfunction

    task automatic scramble_operands();
        bus.src_addr = AW'($urandom);
        bus.dst_addr = AW'($urandom);
        bus.len      = (AW+1)'($urandom);
`ifdef RAM512_COPY_FILL_MODE_EN
        bus.fill       = 1'($urandom);
        bus.fill_value = DW'($urandom);
`endif
    endtask

    // One operation: build the expected access sequence and final memory
    // image from the copy rules, then compare every cycle up to one past done.
    task automatic run_op(input string nm, input int unsigned s, input int unsigned d,
                          input int unsigned l, input bit fl, input logic [DW-1:0] fv,
                          input int unsigned exp_done, input bit hold_start);
        acc_t          tr[$];
        logic [DW-1:0] img [DEPTH];
        int unsigned   leff;
        int unsigned   bad;
        logic [63:0]   exp;
        logic [63:0]   act;
        acc_t          a;
        leff = (l > DEPTH) ? DEPTH : l;
        img  = mem;
        for (int unsigned k = 0; k < leff; k++) begin
            int unsigned   sa;
            int unsigned   da;
            logic [DW-1:0] v;
            sa = (s + k) % DEPTH;
            da = (d + k) % DEPTH;
            v  = fl ? fv : img[sa];
            if (!fl) tr.push_back('{1'b0, AW'(sa), '0});
            img[da] = v;
            tr.push_back('{1'b1, AW'(da), v});
        end

        @(negedge clk);
        bus.start    = 1'b1;
        bus.src_addr = AW'(s);
        bus.dst_addr = AW'(d);
        bus.len      = (AW+1)'(l);
`ifdef RAM512_COPY_FILL_MODE_EN
        bus.fill       = fl;
        bus.fill_value = fv;
`endif
        @(posedge clk);
        #1;
        scramble_operands();
        bus.start = hold_start ? 1'b1 : 1'($urandom);

        for (int unsigned c = 1; c <= exp_done + 1; c++) begin
            @(negedge clk);
            if (c <= tr.size()) begin
                a   = tr[c-1];
                exp = 64'({c <= exp_done, c == exp_done, 1'b1, a.rw, a.addr,
                           a.rw ? a.data : {DW{1'b0}}});
                act = 64'({bus.busy, bus.done, bus.mem_en, bus.mem_rw, bus.mem_address,
                           a.rw ? bus.mem_in : {DW{1'b0}}});
            end else begin
                exp = 64'({c <= exp_done, c == exp_done, 2'b00, {AW{1'b0}}, {DW{1'b0}}});
                act = outs();
            end
            check($sformatf("%s cycle%0d", nm, c), act, exp);
            scramble_operands();
            if (c < exp_done) bus.start = hold_start ? 1'b1 : 1'($urandom);
            else              bus.start = 1'b0;
        end

        bad = 0;
        for (int unsigned k = 0; k < DEPTH; k++) if (mem[k] !== img[k]) bad++;
        check({nm, " mem_image_mismatches"}, 64'(bad), 64'(0));
    endtask

    initial begin
        vec_t          tbl[$];
        logic [DW-1:0] old510;
        logic [DW-1:0] old511;
        int unsigned   s;
        int unsigned   d;
        int unsigned   l;
        int unsigned   leff;
        bit            fl;
        logic [DW-1:0] fv;

        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.src_addr = '0;
        bus.dst_addr = '0;
        bus.len      = '0;
`ifdef RAM512_COPY_FILL_MODE_EN
        bus.fill       = 1'b0;
        bus.fill_value = '0;
`endif
        for (int unsigned k = 0; k < DEPTH; k++) mem[k] = DW'($urandom);

        #1;
        check("reset_outputs_async", outs(), 64'(0));
        repeat (3) @(negedge clk);
        check("reset_outputs_clocked", outs(), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", outs(), 64'(0));

        tbl.push_back('{"basic",   10,  100, 4,   9});
        tbl.push_back('{"wrap",    510, 0,   3,   7});
        tbl.push_back('{"len0",    5,   6,   0,   1});
        tbl.push_back('{"len1",    300, 301, 1,   3});
        tbl.push_back('{"overlap", 20,  22,  5,   11});
        tbl.push_back('{"clamp",   40,  200, 700, 1025});
        tbl.push_back('{"full",    0,   0,   512, 1025});

        mem[10] = 16'hAAAA; mem[11] = 16'hBBBB; mem[12] = 16'hCCCC; mem[13] = 16'hDDDD;
        for (int unsigned t = 0; t < tbl.size(); t++) begin
            if (tbl[t].name == "wrap") begin
                old510 = mem[510];
                old511 = mem[511];
            end
            run_op(tbl[t].name, tbl[t].src, tbl[t].dst, tbl[t].len, 1'b0, '0,
                   tbl[t].exp_done, 1'b0);
            if (tbl[t].name == "basic") begin
                check("basic mem100..103", {mem[100], mem[101], mem[102], mem[103]},
                      64'h AAAA_BBBB_CCCC_DDDD);
            end
            if (tbl[t].name == "wrap") begin
                check("wrap mem0..2", 64'({mem[0], mem[1], mem[2]}),
                      64'({old510, old511, old510}));
            end
        end

        // start held high throughout: one operation, one done pulse
        run_op("hold_start", 50, 60, 3, 1'b0, '0, 7, 1'b1);
        for (int unsigned c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("hold_start idle%0d", c), outs(), 64'(0));
        end

        // randomized operations against the reference model
        for (int unsigned r = 0; r < 20; r++) begin
            s  = $urandom_range(0, DEPTH-1);
            d  = $urandom_range(0, DEPTH-1);
            l  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 24);
            fl = 1'b0;
            fv = DW'($urandom);
`ifdef RAM512_COPY_FILL_MODE_EN
            fl = ($urandom_range(0, 3) == 0);
`endif
            leff = (l > DEPTH) ? DEPTH : l;
            run_op($sformatf("rand%0d", r), s, d, l, fl, fv,
                   fl ? leff + 1 : 2 * leff + 1, 1'b0);
        end

`ifdef RAM512_COPY_FILL_MODE_EN
        run_op("fill", 0, 20, 3, 1'b1, 16'hBEEF, 4, 1'b0);
        check("fill mem20..22", 64'({mem[20], mem[21], mem[22]}), 64'h BEEF_BEEF_BEEF);
`endif

        // reset in cycle 5 of a 4-word copy: two writes land, no done pulse
        mem[10] = 16'h1111; mem[11] = 16'h2222; mem[12] = 16'h3333; mem[13] = 16'h4444;
        for (int unsigned k = 100; k < 104; k++) mem[k] = 16'hF0F0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.src_addr = AW'(10);
        bus.dst_addr = AW'(100);
        bus.len      = (AW+1)'(4);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        for (int unsigned c = 1; c <= 5; c++) @(negedge clk);
        check("pre_reset busy", 64'(bus.busy), 64'(1));
        rst_n = 1'b0;
        #1;
        check("reset_midop outputs", outs(), 64'(0));
        for (int unsigned c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("reset_midop hold%0d", c), outs(), 64'(0));
        end
        rst_n = 1'b1;
        for (int unsigned c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("reset_midop after%0d", c), outs(), 64'(0));
        end
        check("reset_midop mem100..103", {mem[100], mem[101], mem[102], mem[103]},
              64'h 1111_2222_F0F0_F0F0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram512_copy_engine.md
RAM512_COPY_ENGINE -- requirements
Module: ram512_copy_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 16, the memory word width.
REQ-002 SHALL have parameter ADDR_W, default 9, the memory address width (512 words).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, a request to begin a copy, sampled only in IDLE.
REQ-006 SHALL have port src_addr, input, ADDR_W, the first source word address.
REQ-007 SHALL have port dst_addr, input, ADDR_W, the first destination word address.
REQ-008 SHALL have port len, input, ADDR_W+1, the word count, 0..512.
REQ-009 SHALL have port busy, output, 1, high from the cycle after an accepted start through DONE.
REQ-010 SHALL have port done, output, 1, a single-cycle completion pulse.
REQ-011 SHALL have port mem_en, output, 1, the memory enable.
REQ-012 SHALL have port mem_rw, output, 1, the memory direction: 1 = write, 0 = read.
REQ-013 SHALL have port mem_address, output, ADDR_W, the memory word address.
REQ-014 SHALL have port mem_in, output, DATA_W, the memory write data.
REQ-015 SHALL have port mem_out, input, DATA_W, the memory read data, valid combinationally in the cycle mem_en=1 and mem_rw=0.

Function
REQ-016 SHALL implement an FSM with states IDLE, READ, WRITE, DONE.
REQ-017 SHALL, in IDLE with start=1, capture src_addr, dst_addr and len, zero the word index i, and go to READ (len>0) or DONE (len=0).
REQ-018 SHALL, in READ, drive mem_en=1, mem_rw=0, mem_address=src+i, latch mem_out into a hold register at the edge, and go to WRITE.
REQ-019 SHALL, in WRITE, drive mem_en=1, mem_rw=1, mem_address=dst+i, mem_in=hold; at the edge increment i and go to READ if i+1<len, otherwise go to DONE.
REQ-020 SHALL, in DONE, assert done=1 for exactly one cycle, then return to IDLE.
REQ-021 SHALL compute address sums modulo 2^ADDR_W, so 511+1 wraps to 0.
REQ-022 SHALL copy in ascending index order; overlapping regions with dst>src propagate already-written data, and this is the defined behaviour.
REQ-023 SHALL ignore start outside IDLE; captured operands stay frozen for the whole operation.
REQ-024 SHALL drive mem_en=0, mem_rw=0, mem_address=0 and mem_in=0 in IDLE and DONE.
REQ-025 SHALL, for an accepted start at edge 0, place the last write in cycle 2*len and the done pulse in cycle 2*len+1; for len=0, done is in cycle 1 with no memory access.
REQ-026 SHALL, when len>512, clamp the count to 512.

Reset
REQ-027 SHALL, while rst_n=0, force state IDLE and set busy=0, done=0, mem_en=0, mem_rw=0, mem_address=0, mem_in=0, index=0 and hold=0, independent of clk.
REQ-028 SHALL, on reset asserted mid-operation, abort without a done pulse; writes already performed remain.

Configuration
REQ-029 SHALL, with macro RAM512_COPY_FILL_MODE_EN defined, add inputs fill (1) and fill_value (DATA_W), both captured at start.
REQ-030 SHALL, with fill=1 captured, skip READ and write fill_value to dst+i in consecutive WRITE cycles, giving done at cycle len+1.
REQ-031 SHALL, without RAM512_COPY_FILL_MODE_EN, not have the fill or fill_value ports and behave as copy-only.

Verification
REQ-032 SHALL verify basic copy: preload mem[10..13]=A,B,C,D, start with src=10, dst=100, len=4 -> mem[100..103]=A,B,C,D, done in cycle 9, busy high in cycles 1-9.
REQ-033 SHALL verify wrap: src=510, dst=0, len=3 -> reads from 510, 511, 0; writes to 0, 1, 2; mem[0..2]=old mem[510], old mem[511], old mem[510].
REQ-034 SHALL verify len=0: start -> done in cycle 1, mem_en never high.
REQ-035 SHALL verify start held high through the operation and a second start during busy -> exactly one operation and one done pulse.
REQ-036 SHALL verify reset mid-operation: rst_n low at cycle 5 of a len=4 copy -> outputs zero immediately, no done, mem[100..101] written and mem[102..103] unchanged.
REQ-037 SHALL verify fill mode (macro defined): fill=1, fill_value=16'hBEEF, dst=20, len=3 -> mem[20..22]=BEEF, no read cycles, done in cycle 4.
